// File: rtl/hazard_ctrl.sv
// Hazard and fetch-sequencing controller beside IF_ID: stalls on load-use and
// imem wait, flushes on taken branches, squashes a stale wrong-path fetch.
//
// state  | meaning
// RUN    | normal fetch; load-use and imem-wait stalls are resolved here
// SQUASH | branch target issued while a wrong-path fetch is outstanding;
//        | the next returned word is discarded
module hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] if_id_rs1,
   input  logic [REG_W-1:0] if_id_rs2,
   input  logic [REG_W-1:0] id_ex_rd,
   input  logic             id_ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             imem_ready,
   input  logic             counter_clr,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ctrl_state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             lu;

   assign lu = id_ex_mem_read && (id_ex_rd != '0) &&
               ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      state_d      = state_q;
      if (!reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         state_d      = RUN;
      end else if (ex_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         state_d      = imem_ready ? RUN : SQUASH;
      end else if (state_q == SQUASH) begin
         // PC holds the target so it is refetched once the stale word drains
         pc_write    = 1'b0;
         if_id_flush = 1'b1;
         state_d     = imem_ready ? RUN : SQUASH;
      end else if (lu) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (!imem_ready) begin
         pc_write    = 1'b0;
         if_id_flush = 1'b1;
      end
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (counter_clr) begin
         stall_d = '0;
         flush_d = '0;
      end else begin
         if (!pc_write && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_ONE;
         if (ex_branch_taken && (flush_q != CNT_MAX)) flush_d = flush_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= RUN;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign ctrl_state   = state_q;
   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized scoreboard bench for hazard_ctrl: a behavioural model pushes the
// expected per-cycle response, a negedge monitor pops and compares.
module tb_hazard_ctrl;

   localparam int REG_W = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic [REG_W-1:0] if_id_rs1, if_id_rs2, id_ex_rd;
   logic             id_ex_mem_read, ex_branch_taken, imem_ready, counter_clr;

   logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ctrl_state;
   logic [31:0] stall_cycles, flush_count;
   logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_ctrl_state;
   logic [3:0]  s_stall_cycles, s_flush_count;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_W(REG_W), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .id_ex_rd(id_ex_rd),
      .id_ex_mem_read(id_ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .imem_ready(imem_ready), .counter_clr(counter_clr),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .ctrl_state(ctrl_state),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   hazard_ctrl #(.REG_W(REG_W), .CNT_W(4)) dut_small (
      .clk(clk), .reset(reset),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .id_ex_rd(id_ex_rd),
      .id_ex_mem_read(id_ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .imem_ready(imem_ready), .counter_clr(counter_clr),
      .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
      .id_ex_bubble(s_id_ex_bubble), .ctrl_state(s_ctrl_state),
      .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
   );

   typedef struct {
      logic [3:0]  ctl;   // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
      logic        st;
      logic [31:0] stall, flush;
      logic [3:0]  stall4, flush4;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Model: a pending-discard flag plus plain saturating integer counters.
   bit          m_discard;
   longint      m_stall, m_flush, m_stall4, m_flush4;

   function automatic longint sat_inc(longint v, longint maxv);
      return (v >= maxv) ? maxv : v + 1;
   endfunction

   task automatic drive_cycle(input bit rst, input int rs1, input int rs2, input int rd,
                              input bit mr, input bit br, input bit rdy, input bit clr);
      exp_t e;
      bit   hazard;
      reset           = rst;
      if_id_rs1       = REG_W'(rs1);
      if_id_rs2       = REG_W'(rs2);
      id_ex_rd        = REG_W'(rd);
      id_ex_mem_read  = mr;
      ex_branch_taken = br;
      imem_ready      = rdy;
      counter_clr     = clr;
      hazard = mr && rd != 0 && (rd == rs1 || rd == rs2);
      if (!rst)           e.ctl = 4'b0011;
      else if (br)        e.ctl = 4'b1111;
      else if (m_discard) e.ctl = 4'b0110;
      else if (hazard)    e.ctl = 4'b0001;
      else if (!rdy)      e.ctl = 4'b0110;
      else                e.ctl = 4'b1100;
      e.st     = m_discard;
      e.stall  = 32'(m_stall);
      e.flush  = 32'(m_flush);
      e.stall4 = 4'(m_stall4);
      e.flush4 = 4'(m_flush4);
      exp_q.push_back(e);
      if (!rst) begin
         m_discard = 0;
         m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
      end else begin
         // A wrong-path fetch is outstanding until imem delivers a word.
         if (br || m_discard) m_discard = !rdy;
         if (clr) begin
            m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
         end else begin
            if (!e.ctl[3]) begin
               m_stall  = sat_inc(m_stall, 64'hFFFF_FFFF);
               m_stall4 = sat_inc(m_stall4, 15);
            end
            if (br) begin
               m_flush  = sat_inc(m_flush, 64'hFFFF_FFFF);
               m_flush4 = sat_inc(m_flush4, 15);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({pc_write, if_id_write, if_id_flush, id_ex_bubble} != e.ctl ||
                ctrl_state != e.st || stall_cycles != e.stall || flush_count != e.flush ||
                {s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble} != e.ctl ||
                s_stall_cycles != e.stall4 || s_flush_count != e.flush4)
            begin
               miscompares++;
               $display("FAIL vec%0d t=%0t: got ctl=%b st=%b stall=%0d flush=%0d s4=%0d f4=%0d sctl=%b ; expected ctl=%b st=%b stall=%0d flush=%0d s4=%0d f4=%0d",
                        vectors, $time, {pc_write, if_id_write, if_id_flush, id_ex_bubble},
                        ctrl_state, stall_cycles, flush_count, s_stall_cycles, s_flush_count,
                        {s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble},
                        e.ctl, e.st, e.stall, e.flush, e.stall4, e.flush4);
            end
         end
      end
   end

   initial begin : driver
      int rd;
      m_discard = 0;
      m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
      reset = 1'b0; if_id_rs1 = '0; if_id_rs2 = '0; id_ex_rd = '0;
      id_ex_mem_read = 1'b0; ex_branch_taken = 1'b0; imem_ready = 1'b1; counter_clr = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
         drive_cycle(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
      // load-use, then the same with rd = x0
      drive_cycle(1, 0, 5, 5, 1, 0, 1, 0);
      drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
      drive_cycle(1, 0, 0, 0, 1, 0, 1, 0);
      drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
      // branch with fetch ready
      drive_cycle(1, 1, 2, 3, 0, 1, 1, 0);
      drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
      // branch with fetch outstanding, imem returns after two more wait cycles
      drive_cycle(1, 0, 0, 0, 0, 1, 0, 0);
      drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
      drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
      drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
      drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
      // simultaneous events
      drive_cycle(1, 7, 0, 7, 1, 0, 0, 0);
      drive_cycle(1, 7, 0, 7, 1, 1, 1, 0);
      drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
      // clear beats increment
      drive_cycle(1, 3, 3, 3, 1, 0, 1, 1);
      drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
      // long stall saturates the 4-bit counters; also branches to saturate flush
      for (int i = 0; i < 20; i++) drive_cycle(1, 9, 0, 9, 1, 0, 1, 0);
      for (int i = 0; i < 20; i++) drive_cycle(1, 0, 0, 0, 0, 1, 1, 0);
      drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
      // reset while in SQUASH
      drive_cycle(1, 0, 0, 0, 0, 1, 0, 0);
      drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
      drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
      // randomized traffic biased toward hazards
      for (int i = 0; i < 3000; i++) begin
         rd = $urandom_range(0, 3);
         drive_cycle($urandom_range(0, 99) != 0,
                     $urandom_range(0, 3), $urandom_range(0, 3), rd,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
      end
      repeat (3) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
